// File: rtl/std_cache_pkg.sv
// Shared D$ ECC bank definitions: word packing, field offsets and bank FSM states.
// Pure types and constants, no logic.
package std_cache_pkg;

  localparam int DCACHE_ECC_DATA_WIDTH = 176;
  localparam int DCACHE_ECC_TAG_WIDTH  = 44;
  localparam int DCACHE_ECC_WORD_WIDTH = DCACHE_ECC_DATA_WIDTH + DCACHE_ECC_TAG_WIDTH + 2;

  localparam int DCACHE_ECC_DATA_OFS  = 0;
  localparam int DCACHE_ECC_TAG_OFS   = DCACHE_ECC_DATA_WIDTH;
  localparam int DCACHE_ECC_VALID_OFS = DCACHE_ECC_TAG_OFS + DCACHE_ECC_TAG_WIDTH;
  localparam int DCACHE_ECC_DIRTY_OFS = DCACHE_ECC_VALID_OFS + 1;

  typedef struct packed {
    logic                             dirty;
    logic                             valid;
    logic [DCACHE_ECC_TAG_WIDTH-1:0]  tag;
    logic [DCACHE_ECC_DATA_WIDTH-1:0] data;
  } ecc_word_t;

  typedef enum logic {
    INIT,
    IDLE
  } ecc_bank_state_e;

endpackage

// File: rtl/ecc_cache_bank_way.sv
// One way of the ECC bank: masked-write array, read port, optional output register.
// Read latency 1 (OutReg=0) or 2 (OutReg=1); no backpressure. ECC_CACHE_BANK_FAULT_INJECT_EN adds a bit-flip port.
module ecc_cache_bank_way
  import std_cache_pkg::*;
#(
  parameter int NumLines  = 256,
  parameter int WordWidth = DCACHE_ECC_WORD_WIDTH,
  parameter int OutReg    = 0,
  parameter int AddrWidth = $clog2(NumLines),
  parameter int BitWidth  = $clog2(WordWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_en,
  input  logic [AddrWidth-1:0] wr_addr,
  input  logic [WordWidth-1:0] wr_dat,
  input  logic [WordWidth-1:0] wr_mask,
  input  logic                 rd_en,
  input  logic [AddrWidth-1:0] rd_addr,
  input  logic                 inj_en,
  input  logic [AddrWidth-1:0] inj_addr,
  input  logic [BitWidth-1:0]  inj_bit,
  output logic [WordWidth-1:0] rdata
);

  logic [WordWidth-1:0] mem_q [NumLines];
  logic [WordWidth-1:0] rd_word;
  logic [WordWidth-1:0] wr_word;
  logic [WordWidth-1:0] s1_q;

  assign rd_word = mem_q[rd_addr];
  assign wr_word = (wr_dat & wr_mask) | (mem_q[wr_addr] & ~wr_mask);

`ifdef ECC_CACHE_BANK_FAULT_INJECT_EN
  logic [WordWidth-1:0] flip;
  logic [WordWidth-1:0] inj_base;

  always_comb begin
    flip = '0;
    if (int'(inj_bit) < WordWidth) flip[inj_bit] = 1'b1;
  end

  // A flip on the line being written lands on the post-write value.
  assign inj_base = (wr_en && (wr_addr == inj_addr)) ? wr_word : mem_q[inj_addr];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_addr] <= wr_word;
    if (inj_en) mem_q[inj_addr] <= inj_base ^ flip;
  end
`else
  logic unused_inj;
  assign unused_inj = ^{inj_en, inj_addr, inj_bit};

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_addr] <= wr_word;
  end
`endif

  // Captures pre-write contents, so read-during-write returns old data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) s1_q <= '0;
    else if (rd_en) s1_q <= rd_word;
  end

  if (OutReg != 0) begin : g_out_reg
    logic                 s1_vld_q;
    logic [WordWidth-1:0] out_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s1_vld_q <= 1'b0;
        out_q    <= '0;
      end else begin
        s1_vld_q <= rd_en;
        if (s1_vld_q) out_q <= s1_q;
      end
    end

    assign rdata = out_q;
  end else begin : g_no_out_reg
    assign rdata = s1_q;
  end

endmodule

// File: rtl/ecc_cache_bank_resp.sv
// ECC D$ bank responder: per-way arrays, self-clear on reset/flush, sticky busy-request error.
// Read latency 1 or 2 (OutReg); requests ignored while ready_o=0. ECC_CACHE_BANK_FAULT_INJECT_EN enables inj_*.
module ecc_cache_bank_resp
  import std_cache_pkg::*;
#(
  parameter int NumWays   = 8,
  parameter int NumLines  = 256,
  parameter int WordWidth = DCACHE_ECC_WORD_WIDTH,
  parameter int OutReg    = 0,
  parameter int AddrWidth = $clog2(NumLines),
  parameter int WayWidth  = $clog2(NumWays),
  parameter int BitWidth  = $clog2(WordWidth)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumWays-1:0]           req_i,
  input  logic                         we_i,
  input  logic [AddrWidth-1:0]         addr_i,
  input  logic [WordWidth-1:0]         wdata_i,
  input  logic [WordWidth-1:0]         be_i,
  output logic [NumWays*WordWidth-1:0] rdata_o,
  input  logic                         flush_i,
  output logic                         ready_o,
  output logic                         err_req_while_busy_o,
  input  logic                         inj_valid_i,
  input  logic [WayWidth-1:0]          inj_way_i,
  input  logic [AddrWidth-1:0]         inj_addr_i,
  input  logic [BitWidth-1:0]          inj_bit_i
);

  ecc_bank_state_e      state_q;
  logic [AddrWidth-1:0] cnt_q;
  logic                 ready_q;
  logic                 err_q;

  logic                 init_wr;
  logic                 accept;
  logic [NumWays-1:0]   acc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if ((|req_i) && !ready_q) err_q <= 1'b1;
      case (state_q)
        INIT: begin
          if (flush_i) begin
            cnt_q <= '0;
          end else if (cnt_q == AddrWidth'(NumLines - 1)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IDLE: begin
          if (flush_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= INIT;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o              = ready_q;
  assign err_req_while_busy_o = err_q;

  // Flush wins over a same-cycle request.
  assign init_wr = (state_q == INIT);
  assign accept  = (state_q == IDLE) && !flush_i;
  assign acc     = req_i & {NumWays{accept}};

  for (genvar w = 0; w < NumWays; w++) begin : g_way
    logic way_wr_en;
    logic way_inj_en;

    assign way_wr_en  = init_wr || (acc[w] && we_i);
    assign way_inj_en = inj_valid_i && (state_q == IDLE) && (inj_way_i == WayWidth'(w));

    ecc_cache_bank_way #(
      .NumLines  (NumLines),
      .WordWidth (WordWidth),
      .OutReg    (OutReg),
      .AddrWidth (AddrWidth),
      .BitWidth  (BitWidth)
    ) u_way (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .wr_en    (way_wr_en),
      .wr_addr  (init_wr ? cnt_q : addr_i),
      .wr_dat   (init_wr ? '0 : wdata_i),
      .wr_mask  (init_wr ? '1 : be_i),
      .rd_en    (acc[w]),
      .rd_addr  (addr_i),
      .inj_en   (way_inj_en),
      .inj_addr (inj_addr_i),
      .inj_bit  (inj_bit_i),
      .rdata    (rdata_o[w*WordWidth +: WordWidth])
    );
  end

endmodule

// File: tb/tb_ecc_cache_bank_resp.sv
// Directed bench for ecc_cache_bank_resp (default OutReg=0); inject scenario under ECC_CACHE_BANK_FAULT_INJECT_EN.
module tb_ecc_cache_bank_resp;

  localparam int NW  = 8;
  localparam int NL  = 256;
  localparam int WW  = 222;
  localparam int AW  = 8;
  localparam int WYW = 3;
  localparam int BW  = 8;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [NW-1:0]        req_i = '0;
  logic                 we_i = 1'b0;
  logic [AW-1:0]        addr_i = '0;
  logic [WW-1:0]        wdata_i = '0;
  logic [WW-1:0]        be_i = '0;
  logic [NW*WW-1:0]     rdata_o;
  logic                 flush_i = 1'b0;
  logic                 ready_o;
  logic                 err_req_while_busy_o;
  logic                 inj_valid_i = 1'b0;
  logic [WYW-1:0]       inj_way_i = '0;
  logic [AW-1:0]        inj_addr_i = '0;
  logic [BW-1:0]        inj_bit_i = '0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [WW-1:0] ones;
  logic [WW-1:0] zero;
  logic [WW-1:0] mask22;
  logic [WW-1:0] pat;

  always #5 clk_i = ~clk_i;

  ecc_cache_bank_resp dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .req_i                (req_i),
    .we_i                 (we_i),
    .addr_i               (addr_i),
    .wdata_i              (wdata_i),
    .be_i                 (be_i),
    .rdata_o              (rdata_o),
    .flush_i              (flush_i),
    .ready_o              (ready_o),
    .err_req_while_busy_o (err_req_while_busy_o),
    .inj_valid_i          (inj_valid_i),
    .inj_way_i            (inj_way_i),
    .inj_addr_i           (inj_addr_i),
    .inj_bit_i            (inj_bit_i)
  );

  function automatic logic [WW-1:0] rd(input int w);
    return rdata_o[w*WW +: WW];
  endfunction

  // Inputs change on negedge; one posedge later the response is sampled on the next negedge.
  task automatic drive(input logic [NW-1:0] r, input logic w, input logic [AW-1:0] a,
                       input logic [WW-1:0] d, input logic [WW-1:0] m);
    req_i = r; we_i = w; addr_i = a; wdata_i = d; be_i = m;
    @(negedge clk_i);
    req_i = '0; we_i = 1'b0; wdata_i = '0; be_i = '0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready_o && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    tests_run++;
    if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    tests_run++;
    if (rdata_o !== '0) begin tests_failed++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
    tests_run++;
    if (err_req_while_busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", err_req_while_busy_o); end
    rst_ni = 1'b1;
    wait_ready(n);
    tests_run++;
    if (n != NL) begin tests_failed++; $display("FAIL init_cycles: got %0d want %0d", n, NL); end
    drive(8'hFF, 1'b0, 8'd255, zero, zero);
    for (int w = 0; w < NW; w++) begin
      tests_run++;
      if (rd(w) !== zero) begin tests_failed++; $display("FAIL init_line255_way%0d: got %h want 0", w, rd(w)); end
    end
  endtask

  task automatic test_write_read;
    drive(8'h04, 1'b1, 8'h10, ones, ones);
    tests_run++;
    if (rd(2) !== zero) begin tests_failed++; $display("FAIL wr_old_way2: got %h want 0", rd(2)); end
    drive(8'h0C, 1'b0, 8'h10, zero, zero);
    tests_run++;
    if (rd(2) !== ones) begin tests_failed++; $display("FAIL rd_way2: got %h want %h", rd(2), ones); end
    tests_run++;
    if (rd(3) !== zero) begin tests_failed++; $display("FAIL rd_way3: got %h want 0", rd(3)); end
  endtask

  task automatic test_partial_mask;
    drive(8'h02, 1'b1, 8'd5, ones, ones);
    drive(8'h02, 1'b1, 8'd5, zero, mask22);
    tests_run++;
    if (rd(1) !== ones) begin tests_failed++; $display("FAIL mask_wr_old: got %h want %h", rd(1), ones); end
    drive(8'h02, 1'b0, 8'd5, zero, zero);
    tests_run++;
    if (rd(1) !== (ones & ~mask22)) begin tests_failed++; $display("FAIL mask_rd: got %h want %h", rd(1), ones & ~mask22); end
    drive(8'h02, 1'b1, 8'd5, zero, zero);
    drive(8'h02, 1'b0, 8'd5, zero, zero);
    tests_run++;
    if (rd(1) !== (ones & ~mask22)) begin tests_failed++; $display("FAIL be0_unchanged: got %h want %h", rd(1), ones & ~mask22); end
    tests_run++;
    if (rd(2) !== ones) begin tests_failed++; $display("FAIL hold_way2: got %h want %h", rd(2), ones); end
  endtask

  task automatic test_back_to_back;
    drive(8'h10, 1'b1, 8'd8, pat, ones);
    drive(8'h10, 1'b0, 8'd8, zero, zero);
    tests_run++;
    if (rd(4) !== pat) begin tests_failed++; $display("FAIL b2b_rd_way4: got %h want %h", rd(4), pat); end
    drive(8'h60, 1'b1, 8'd9, ~pat, ones);
    drive(8'h70, 1'b0, 8'd9, zero, zero);
    tests_run++;
    if (rd(5) !== ~pat) begin tests_failed++; $display("FAIL multi_way5: got %h want %h", rd(5), ~pat); end
    tests_run++;
    if (rd(6) !== ~pat) begin tests_failed++; $display("FAIL multi_way6: got %h want %h", rd(6), ~pat); end
    tests_run++;
    if (rd(4) !== zero) begin tests_failed++; $display("FAIL multi_way4_line9: got %h want 0", rd(4)); end
    drive(8'h10, 1'b1, 8'd8, ~pat, ones);
    tests_run++;
    if (rd(4) !== pat) begin tests_failed++; $display("FAIL rdw_old: got %h want %h", rd(4), pat); end
    drive(8'h10, 1'b0, 8'd8, zero, zero);
    tests_run++;
    if (rd(4) !== ~pat) begin tests_failed++; $display("FAIL rdw_new: got %h want %h", rd(4), ~pat); end
  endtask

  task automatic test_flush;
    int n;
    flush_i = 1'b1;
    drive(8'h01, 1'b1, 8'd7, ones, ones);
    flush_i = 1'b0;
    wait_ready(n);
    tests_run++;
    if (n != NL) begin tests_failed++; $display("FAIL flush_busy_cycles: got %0d want %0d", n, NL); end
    drive(8'h05, 1'b0, 8'd7, zero, zero);
    tests_run++;
    if (rd(0) !== zero) begin tests_failed++; $display("FAIL flush_line7: got %h want 0", rd(0)); end
    drive(8'h04, 1'b0, 8'h10, zero, zero);
    tests_run++;
    if (rd(2) !== zero) begin tests_failed++; $display("FAIL flush_cleared_way2: got %h want 0", rd(2)); end
    tests_run++;
    if (err_req_while_busy_o !== 1'b0) begin tests_failed++; $display("FAIL flush_no_err: got %b want 0", err_req_while_busy_o); end
  endtask

  task automatic test_busy_err;
    int n;
    drive(8'h01, 1'b1, 8'd9, ones, ones);
    drive(8'h01, 1'b0, 8'd9, zero, zero);
    tests_run++;
    if (rd(0) !== ones) begin tests_failed++; $display("FAIL busy_setup: got %h want %h", rd(0), ones); end
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    repeat (10) @(negedge clk_i);
    drive(8'h01, 1'b1, 8'd0, ones, ones);
    drive(8'h01, 1'b0, 8'd0, zero, zero);
    tests_run++;
    if (err_req_while_busy_o !== 1'b1) begin tests_failed++; $display("FAIL busy_err_set: got %b want 1", err_req_while_busy_o); end
    tests_run++;
    if (rd(0) !== ones) begin tests_failed++; $display("FAIL busy_rdata_hold: got %h want %h", rd(0), ones); end
    wait_ready(n);
    tests_run++;
    if (n >= 2000) begin tests_failed++; $display("FAIL busy_ready_timeout: got %0d cycles", n); end
    tests_run++;
    if (err_req_while_busy_o !== 1'b1) begin tests_failed++; $display("FAIL busy_err_sticky: got %b want 1", err_req_while_busy_o); end
    drive(8'h01, 1'b0, 8'd0, zero, zero);
    tests_run++;
    if (rd(0) !== zero) begin tests_failed++; $display("FAIL busy_write_dropped: got %h want 0", rd(0)); end
  endtask

`ifdef ECC_CACHE_BANK_FAULT_INJECT_EN
  task automatic test_inject;
    logic [WW-1:0] b4;
    b4 = '0;
    b4[4] = 1'b1;
    drive(8'h01, 1'b1, 8'd3, zero, ones);
    inj_valid_i = 1'b1; inj_way_i = 3'd0; inj_addr_i = 8'd3; inj_bit_i = 8'd4;
    @(negedge clk_i);
    inj_valid_i = 1'b0;
    drive(8'h01, 1'b0, 8'd3, zero, zero);
    tests_run++;
    if (rd(0) !== b4) begin tests_failed++; $display("FAIL inj_flip: got %h want %h", rd(0), b4); end
    inj_valid_i = 1'b1;
    drive(8'h01, 1'b1, 8'd3, ones, ones);
    inj_valid_i = 1'b0;
    drive(8'h01, 1'b0, 8'd3, zero, zero);
    tests_run++;
    if (rd(0) !== (ones ^ b4)) begin tests_failed++; $display("FAIL inj_post_write: got %h want %h", rd(0), ones ^ b4); end
    inj_valid_i = 1'b1; inj_bit_i = 8'd230;
    @(negedge clk_i);
    inj_valid_i = 1'b0;
    drive(8'h01, 1'b0, 8'd3, zero, zero);
    tests_run++;
    if (rd(0) !== (ones ^ b4)) begin tests_failed++; $display("FAIL inj_oob_ignored: got %h want %h", rd(0), ones ^ b4); end
  endtask
`endif

  task automatic test_reset_mid;
    int n;
    drive(8'h01, 1'b1, 8'd2, ones, ones);
    drive(8'h01, 1'b0, 8'd2, zero, zero);
    tests_run++;
    if (rd(0) !== ones) begin tests_failed++; $display("FAIL mid_setup: got %h want %h", rd(0), ones); end
    req_i = 8'h01; addr_i = 8'd2;
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    req_i = '0;
    #1;
    tests_run++;
    if (rdata_o !== '0) begin tests_failed++; $display("FAIL mid_rdata: got %h want 0", rdata_o); end
    tests_run++;
    if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL mid_ready: got %b want 0", ready_o); end
    tests_run++;
    if (err_req_while_busy_o !== 1'b0) begin tests_failed++; $display("FAIL mid_err: got %b want 0", err_req_while_busy_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    wait_ready(n);
    tests_run++;
    if (n != NL) begin tests_failed++; $display("FAIL mid_init_cycles: got %0d want %0d", n, NL); end
    drive(8'h01, 1'b0, 8'd2, zero, zero);
    tests_run++;
    if (rd(0) !== zero) begin tests_failed++; $display("FAIL mid_cleared: got %h want 0", rd(0)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ones   = '1;
    zero   = '0;
    mask22 = '0;
    mask22[21:0] = '1;
    pat    = {111{2'b10}};
    test_reset;
    test_write_read;
    test_partial_mask;
    test_back_to_back;
    test_flush;
    test_busy_err;
`ifdef ECC_CACHE_BANK_FAULT_INJECT_EN
    test_inject;
`endif
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ecc_cache_bank_resp.md
Name: ecc_cache_bank_resp

Overview:
- Responder end of the ECC-protected D$ memory interface. Terminates the bank-side request/rdata protocol driven by the cache tag-compare/scrubber path.
- Holds one ECC-encoded word per way per line: data+ECC, tag, valid, dirty packed into WordWidth bits.
- Applies bit-granular write masks and returns read data per way with fixed latency.
- Self-clears the array to the all-zero codeword after reset or on flush; the all-zero word is a valid Hsiao codeword with valid=0.

Parameters:
- NumWays, 8, number of ways; one storage array per way.
- NumLines, 256, lines per way.
- WordWidth, 222, stored word width per way: 176 data+ECC, 44 tag, 1 valid, 1 dirty.
- OutReg, 0, 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- AddrWidth, $clog2(NumLines), line index width (derived; do not override).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. Asynchronous, active-low. Clock is clk_i.
- req_i  in  NumWays  per-way access request.
- we_i  in  1  write enable, common to all requested ways.
- addr_i  in  AddrWidth  line index.
- wdata_i  in  WordWidth  write word, broadcast to all requested ways.
- be_i  in  WordWidth  bit-level write mask; 1 means write that bit.
- rdata_o  out  NumWays*WordWidth  per-way read data.
- flush_i  in  1  single-cycle pulse; restarts array clear.
- ready_o  out  1  high when the bank accepts requests.
- err_req_while_busy_o  out  1  sticky; set if any req_i bit is high while ready_o=0.
- inj_valid_i  in  1  fault-inject strobe (only with the optional feature).
- inj_way_i  in  $clog2(NumWays)  injection target way.
- inj_addr_i  in  AddrWidth  injection target line.
- inj_bit_i  in  $clog2(WordWidth)  bit to flip.

Behaviour:
- Reset values: ready_o=0, rdata_o=0, err_req_while_busy_o=0, FSM=INIT, init counter=0. Array contents are not reset.
- FSM states: INIT, IDLE.
- INIT: each cycle writes 0 to line cnt of all ways; cnt increments.
  - When cnt==NumLines-1 is written, go to IDLE next cycle and set ready_o=1.
  - Clearing takes exactly NumLines cycles after reset deassertion.
- IDLE: ready_o=1. flush_i=1 takes priority over any same-cycle request: the request is dropped, FSM goes to INIT, cnt=0, ready_o=0 next cycle.
- flush_i during INIT restarts the clear with cnt=0.
- Requests while ready_o=0 are ignored: no write, rdata unchanged. err_req_while_busy_o sets and clears only on reset.
- Read (req_i[w]=1, we_i=0): rdata_o[w] = mem[w][addr] after 1 cycle (OutReg=0) or 2 cycles (OutReg=1).
- Ways without req hold their previous rdata_o value (SRAM hold semantics).
- Write (req_i[w]=1, we_i=1): mem[w][addr] <= (wdata_i & be_i) | (mem & ~be_i).
  - Read-during-write: rdata_o[w] returns the old contents, latency as for a read.
- be_i=0 with we_i=1 leaves contents unchanged but still returns the old data.
- Multiple ways may be requested in one cycle; each way is independent.
- Same-cycle write then read of the same line in the next cycle returns the new data.
- OutReg=1: output register updates only when the stage-1 valid bit for that way is set; otherwise it holds.
- Reset mid-operation: everything returns to INIT, and any pipelined read is discarded (rdata_o=0).

Optional Feature:
- Macro: ECC_CACHE_BANK_FAULT_INJECT_EN.
- Defined, in IDLE: inj_valid_i=1 XORs bit inj_bit_i of mem[inj_way_i][inj_addr_i] at the clock edge.
  - If a write to the same way/line occurs in the same cycle, the flip is applied to the post-write value.
  - Injection is ignored during INIT.
  - inj_bit_i>=WordWidth is ignored.
- Undefined: inj_* ports still exist and are ignored; no XOR logic is synthesised.

Decomposition:
- Shared std_cache_pkg additions:
  - ecc_bank_state_e {INIT, IDLE}.
  - Localparam DCACHE_ECC_WORD_WIDTH for the 222-bit packing.
  - Field offset constants for tag, valid and dirty.
- Sub-module ecc_cache_bank_way: one per way.
  - Contents: behavioral masked-write array, read port, optional output register, injection XOR.
  - Instantiated NumWays times under a generate loop.
  - The FSM and init counter stay in the top.

Test Plan:
- Reset release, count cycles until ready_o=1 -> exactly 256 cycles; a read of line 255 in every way returns 0.
- Write way2 line 0x10, wdata all ones, be all ones; then read line 0x10 on ways 2 and 3 -> way2 returns all ones, way3 returns 0, one cycle after the read request (two with OutReg=1).
- Write way1 line 5 with all ones; then write wdata=0 with be bits [21:0] set; read -> bits [21:0]=0, all other bits 1; the write cycle itself returns all ones (old data).
- Pulse flush_i together with a write to line 7 -> write dropped; ready_o=0 for 256 cycles; line 7 reads 0.
- Assert req_i=0x01 during INIT -> err_req_while_busy_o=1 and stays set after INIT; no array change.
- With ECC_CACHE_BANK_FAULT_INJECT_EN: write 0 to way0 line 3, inject bit 4 on way0 line 3, read -> word equals 0x10. Same-cycle write of all ones plus injection on bit 4 -> read returns all ones except bit 4.
